// File: rtl/jtframe_prog_pkg.sv
// rtl/jtframe_prog_pkg.sv - shared types and constants for the ioctl-to-SDRAM programming packer
package jtframe_prog_pkg;

    // Widest word address an entry can carry; prog_addr is cut down to SDRAMW on the way out.
    localparam int PROG_AW = 25;

    // 1 = byte not written; bit 1 covers data[15:8]
    localparam logic [1:0] MASK_FULL    = 2'b00;
    localparam logic [1:0] MASK_LO_ONLY = 2'b10;
    localparam logic [1:0] MASK_HI_ONLY = 2'b01;

    typedef enum logic {
        IDLE,
        WRITE
    } prog_state_t;

    typedef struct packed {
        logic [1:0]         ba;
        logic [PROG_AW-1:0] addr;
        logic [15:0]        data;
        logic [1:0]         mask;
    } prog_entry_t;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// rtl/jtframe_prog_fifo.sv - synchronous FIFO of packed programming words with simultaneous push/pop
module jtframe_prog_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jtframe_prog_packer.sv
// rtl/jtframe_prog_packer.sv - packs the byte-wide ioctl download into masked 16-bit SDRAM programming writes
module jtframe_prog_packer #(
    parameter int          SDRAMW     = 23,
    parameter logic [24:0] BA1_START  = 25'h040_0000,
    parameter logic [24:0] BA2_START  = 25'h080_0000,
    parameter logic [24:0] BA3_START  = 25'h0C0_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          SWAB       = 0
) (
    input  logic              clk_rom,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              overflow
);
    import jtframe_prog_pkg::*;

    logic              acc;
    logic              same_word;
    logic [1:0]        in_ba;
    logic [24:0]       in_off;
    logic [SDRAMW-1:0] in_word;

    logic              dl_q;
    logic              pend_valid, pend_valid_n;
    logic              pend_odd, pend_odd_n;
    logic [1:0]        pend_ba, pend_ba_n;
    logic [SDRAMW-1:0] pend_word, pend_word_n;
    logic [7:0]        pend_data, pend_data_n;

    logic              push;
    prog_entry_t       push_entry;
    prog_entry_t       head;
    logic              full;
    logic              empty;
    logic              pop;
    prog_state_t       state, state_n;

    function automatic prog_entry_t make_entry(
        input logic [1:0]        ba,
        input logic [SDRAMW-1:0] word,
        input logic [7:0]        even_b,
        input logic [7:0]        odd_b,
        input logic              has_even,
        input logic              has_odd
    );
        prog_entry_t e;
        logic [7:0]  ev;
        logic [7:0]  od;
        ev     = has_even ? even_b : 8'h00;
        od     = has_odd  ? odd_b  : 8'h00;
        e.ba   = ba;
        e.addr = PROG_AW'(word);
        e.data = (SWAB != 0) ? {ev, od} : {od, ev};
        if (has_even && has_odd)         e.mask = MASK_FULL;
        else if (has_even == (SWAB == 0)) e.mask = MASK_LO_ONLY;
        else                             e.mask = MASK_HI_ONLY;
        return e;
    endfunction

    always_comb begin
        if (ioctl_addr >= BA3_START) begin
            in_ba  = 2'd3;
            in_off = ioctl_addr - BA3_START;
        end else if (ioctl_addr >= BA2_START) begin
            in_ba  = 2'd2;
            in_off = ioctl_addr - BA2_START;
        end else if (ioctl_addr >= BA1_START) begin
            in_ba  = 2'd1;
            in_off = ioctl_addr - BA1_START;
        end else begin
            in_ba  = 2'd0;
            in_off = ioctl_addr;
        end
    end

    assign in_word = SDRAMW'(in_off >> 1);

    // pend_odd marks an odd byte whose push was deferred because the cycle's push slot was taken
    always_comb begin
        acc          = ioctl_wr && downloading;
        same_word    = pend_valid && !pend_odd && (in_ba == pend_ba) && (in_word == pend_word);
        push         = 1'b0;
        push_entry   = '0;
        pend_valid_n = pend_valid;
        pend_odd_n   = pend_odd;
        pend_ba_n    = pend_ba;
        pend_word_n  = pend_word;
        pend_data_n  = pend_data;
        if (pend_valid && pend_odd) begin
            push         = 1'b1;
            push_entry   = make_entry(pend_ba, pend_word, 8'h00, pend_data, 1'b0, 1'b1);
            pend_valid_n = 1'b0;
            pend_odd_n   = 1'b0;
        end else if (acc) begin
            if (same_word && ioctl_addr[0]) begin
                push         = 1'b1;
                push_entry   = make_entry(pend_ba, pend_word, pend_data, ioctl_data, 1'b1, 1'b1);
                pend_valid_n = 1'b0;
            end else begin
                if (pend_valid && !same_word) begin
                    push       = 1'b1;
                    push_entry = make_entry(pend_ba, pend_word, pend_data, 8'h00, 1'b1, 1'b0);
                end
                pend_valid_n = 1'b1;
                pend_odd_n   = ioctl_addr[0];
                pend_ba_n    = in_ba;
                pend_word_n  = in_word;
                pend_data_n  = ioctl_data;
                if (ioctl_addr[0] && !pend_valid) begin
                    push         = 1'b1;
                    push_entry   = make_entry(in_ba, in_word, 8'h00, ioctl_data, 1'b0, 1'b1);
                    pend_valid_n = 1'b0;
                    pend_odd_n   = 1'b0;
                end
            end
        end else if (dl_q && !downloading && pend_valid) begin
            push         = 1'b1;
            push_entry   = make_entry(pend_ba, pend_word, pend_data, 8'h00, 1'b1, 1'b0);
            pend_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            pend_valid <= 1'b0;
            pend_odd   <= 1'b0;
            pend_ba    <= '0;
            pend_word  <= '0;
            pend_data  <= '0;
            overflow   <= 1'b0;
        end else begin
            dl_q       <= downloading;
            pend_valid <= pend_valid_n;
            pend_odd   <= pend_odd_n;
            pend_ba    <= pend_ba_n;
            pend_word  <= pend_word_n;
            pend_data  <= pend_data_n;
            if (push && full && !pop)        overflow <= 1'b1;
            else if (downloading && !dl_q)   overflow <= 1'b0;
        end
    end

    jtframe_prog_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (prog_entry_t)
    ) u_fifo (
        .clk   (clk_rom),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // The head stays in the FIFO until prog_rdy, so it is stable for the whole write
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE:    if (!empty) state_n = WRITE;
            WRITE: begin
                if (prog_rdy) begin
                    pop     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign prog_we    = (state == WRITE);
    assign prog_ba    = prog_we ? head.ba : 2'b00;
    assign prog_addr  = prog_we ? SDRAMW'(head.addr) : '0;
    assign prog_data  = prog_we ? head.data : 16'h0000;
    assign prog_mask  = prog_we ? head.mask : 2'b00;
    assign dwnld_busy = downloading || pend_valid || !empty || prog_we;

endmodule
